schk_ctrl: RTL and testbench
============================

SCHK_CTRL -- requirements
Module: schk_ctrl

Interface
REQ-001 Parameter DW, 16, width in bits of each serial frame.
REQ-002 Parameter RUN, 10, count of consecutive 1s that forms one detection.
REQ-003 Port CLK, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port RST, input, 1, synchronous active-high reset, sampled on the rising CLK edge.
REQ-005 Port REQA, input, 1, requester A frame request, level, held until ACKA.
REQ-006 Port DATA, input, DW, requester A frame; valid while REQA is high.
REQ-007 Port REQB, input, 1, requester B frame request, level, held until ACKB.
REQ-008 Port DATB, input, DW, requester B frame; valid while REQB is high.
REQ-009 Port ACKA / ACKB, output, 1 each, one-cycle pulse when that requester's frame is captured.
REQ-010 Port SDO, output, 1, serial bit currently presented to the checker, MSB first.
REQ-011 Port BUSY, output, 1, high in LOAD and SHIFT.
REQ-012 Port DET, output, 1, one-cycle pulse when the run counter reaches RUN.
REQ-013 Port DONE, output, 1, one-cycle frame-complete pulse.
REQ-014 Port SRC, output, 1, source of the last completed frame: 0 = A, 1 = B; valid from DONE until the next DONE.
REQ-015 Port HITS, output, 5, number of DET pulses in the last frame; valid from DONE until the next DONE.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, SHIFT and FIN.
REQ-017 IDLE: if REQA or REQB is high, the FSM SHALL go to LOAD; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be decided in IDLE.
- Only one requester high: that requester is granted.
- Both high: grant goes to the requester not served last.
- After reset, A is treated as "not served last".
REQ-019 LOAD, one cycle:
- Capture the granted frame into the shift register.
- Pulse the grant's ACK.
- Clear the bit counter, run counter and hit counter.
- Go to SHIFT.
REQ-020 SHIFT, exactly DW cycles:
- SDO = shift register MSB.
- Each cycle, shift left by one with zero fill.
- After the DW-th bit, go to FIN.
REQ-021 Run counter, per SHIFT cycle:
- SDO = 0: counter SHALL clear to 0.
- SDO = 1 and counter = RUN: counter SHALL load 1.
- SDO = 1 otherwise: counter SHALL increment.
REQ-022 DET SHALL pulse in the cycle after the counter becomes RUN, and SHALL be low outside SHIFT and FIN.
REQ-023 The hit counter SHALL increment on each DET and SHALL saturate at 31.
REQ-024 FIN, one cycle:
- Pulse DONE.
- Update SRC and HITS.
- Go to IDLE.
- BUSY is low.
REQ-025 A frame start-to-DONE SHALL take DW+2 cycles after LOAD entry; back-to-back requests SHALL have one IDLE cycle between frames.
REQ-026 SDO SHALL be 0 in IDLE, LOAD and FIN.
REQ-027 A requester dropping REQ during LOAD or SHIFT SHALL NOT abort the frame already captured.
REQ-028 An illegal state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-029 RST high at a rising edge SHALL force, on that edge:
- state IDLE, round-robin pointer = A;
- SDO, BUSY, DET, DONE, ACKA, ACKB, SRC = 0;
- HITS = 0;
- shift register and all counters = 0.
REQ-030 RST asserted mid-frame SHALL abandon the frame with no DONE pulse; reset SHALL take priority over every other event.

Verification
REQ-031 REQA=1, DATA=16'hFFFF, REQB=0 -> ACKA at LOAD, DET pulses after bits 10 and 20-equivalent, so only one fits; DONE with SRC=0, HITS=1, DONE at cycle 18.
REQ-032 DATA=16'hFFC0 (ten 1s then 0s) -> exactly one DET; HITS=1. DATA=16'hFF80 (nine 1s) -> HITS=0.
REQ-033 REQA=REQB=1 held continuously after reset -> service order A,B,A,B; one IDLE cycle between DONE and the next ACK.
REQ-034 RST pulsed at SHIFT bit 7 -> no DONE; all outputs 0 next cycle; the following REQB frame is granted normally.
REQ-035 REQA dropped one cycle after ACKA -> frame completes with DW bits on SDO matching the captured DATA, MSB first.
REQ-036 DATA=16'hFFFF with RUN=4 -> DET every 4th 1; HITS=4; run counter wraps to 1 after RUN, not 0.

Source files
------------

// File: rtl/schk_ctrl.sv
// Serial run checker: arbitrates two frame requesters, shifts the granted
// frame out MSB first and counts runs of RUN consecutive ones.
module schk_ctrl #(
  parameter int DW  = 16,
  parameter int RUN = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQA,
  input  logic [DW-1:0] DATA,
  input  logic          REQB,
  input  logic [DW-1:0] DATB,
  output logic          ACKA,
  output logic          ACKB,
  output logic          SDO,
  output logic          BUSY,
  output logic          DET,
  output logic          DONE,
  output logic          SRC,
  output logic [4:0]    HITS
);

  localparam int BW = $clog2(DW + 1);
  localparam int RW = $clog2(RUN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] sreg;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] run_cnt;
  logic [4:0]    hit_cnt;
  logic          prio_b;
  logic          cur_b;

  logic          grant_b;
  logic [RW-1:0] run_next;
  logic          det_next;
  logic [4:0]    hit_next;

  // B wins alone, or on a tie when A was served last
  assign grant_b = REQB && (!REQA || prio_b);

  always_comb begin
    run_next = '0;
    if (SDO) begin
      if (run_cnt == RW'(RUN))
        run_next = RW'(1);
      else
        run_next = run_cnt + RW'(1);
    end
  end

  assign det_next = (run_next == RW'(RUN));

  always_comb begin
    hit_next = hit_cnt;
    if (det_next && hit_cnt != 5'd31)
      hit_next = hit_cnt + 5'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      run_cnt <= '0;
      hit_cnt <= '0;
      prio_b  <= 1'b0;
      cur_b   <= 1'b0;
      SDO     <= 1'b0;
      BUSY    <= 1'b0;
      DET     <= 1'b0;
      DONE    <= 1'b0;
      ACKA    <= 1'b0;
      ACKB    <= 1'b0;
      SRC     <= 1'b0;
      HITS    <= '0;
    end else begin
      ACKA <= 1'b0;
      ACKB <= 1'b0;
      DONE <= 1'b0;
      DET  <= 1'b0;
      unique case (state)
        IDLE: begin
          SDO  <= 1'b0;
          BUSY <= 1'b0;
          if (REQA || REQB) begin
            state <= LOAD;
            BUSY  <= 1'b1;
            cur_b <= grant_b;
            if (grant_b) begin
              sreg   <= DATB;
              ACKB   <= 1'b1;
              prio_b <= 1'b0;
            end else begin
              sreg   <= DATA;
              ACKA   <= 1'b1;
              prio_b <= 1'b1;
            end
          end
        end
        LOAD: begin
          state   <= SHIFT;
          SDO     <= sreg[DW-1];
          sreg    <= sreg << 1;
          bit_cnt <= BW'(1);
          run_cnt <= '0;
          hit_cnt <= '0;
        end
        SHIFT: begin
          run_cnt <= run_next;
          DET     <= det_next;
          hit_cnt <= hit_next;
          if (bit_cnt == BW'(DW)) begin
            state <= FIN;
            SDO   <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            SRC   <= cur_b;
            HITS  <= hit_next;
          end else begin
            SDO     <= sreg[DW-1];
            sreg    <= sreg << 1;
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          SDO   <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_schk_ctrl.sv
// Scoreboard bench for schk_ctrl: random frames from two requesters,
// reference run counts derived from the ones-run lengths of each frame.
module tb_schk_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQA, REQB;
  logic [15:0] DATA, DATB;
  logic        ACKA, ACKB, SDO, BUSY, DET, DONE, SRC;
  logic [4:0]  HITS;

  logic        reqa4;
  logic [15:0] data4;
  logic        acka4, ackb4, sdo4, busy4, det4, done4, src4;
  logic [4:0]  hits4;

  always #5 CLK = ~CLK;

  schk_ctrl #(.DW(16), .RUN(10)) dut (
    .CLK(CLK), .RST(RST),
    .REQA(REQA), .DATA(DATA), .REQB(REQB), .DATB(DATB),
    .ACKA(ACKA), .ACKB(ACKB), .SDO(SDO), .BUSY(BUSY),
    .DET(DET), .DONE(DONE), .SRC(SRC), .HITS(HITS)
  );

  schk_ctrl #(.DW(16), .RUN(4)) dut4 (
    .CLK(CLK), .RST(RST),
    .REQA(reqa4), .DATA(data4), .REQB(1'b0), .DATB(16'h0000),
    .ACKA(acka4), .ACKB(ackb4), .SDO(sdo4), .BUSY(busy4),
    .DET(det4), .DONE(done4), .SRC(src4), .HITS(hits4)
  );

  typedef struct {
    bit          src;
    logic [15:0] data;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   mon_act = 0;
  bit   last_b  = 1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Each maximal run of L ones yields L/run detections
  function automatic int ref_hits(logic [15:0] d, int run);
    int len = 0;
    int h = 0;
    for (int i = 15; i >= 0; i--) begin
      if (d[i]) len++;
      else begin
        h += len / run;
        len = 0;
      end
    end
    h += len / run;
    return (h > 31) ? 31 : h;
  endfunction

  function automatic logic [15:0] rnd_data();
    logic [15:0] m;
    m = 16'h03FF;
    case ($urandom_range(0, 3))
      0: return 16'($urandom);
      1: return 16'hFFFF;
      2: return (m << $urandom_range(0, 6)) | 16'($urandom);
      default: return 16'($urandom) & 16'($urandom);
    endcase
  endfunction

  // Monitor: samples on the falling edge, driver moves at negedge+2
  initial begin : mon
    exp_t cur;
    int   k = 0;
    int   dets = 0;
    int   done_cyc = 0;
    bit   pend = 0;
    bit   have_done = 0;
    cur = '{1'b0, 16'h0};
    forever begin
      @(negedge CLK);
      if (RST) begin
        mon_act = 0;
        pend = 0;
        have_done = 0;
        expq.delete();
        continue;
      end
      if (mon_act) begin
        k++;
        if (k <= 16) begin
          chk("sdo_bit", SDO, cur.data[16-k]);
          chk("busy_shift", BUSY, 1);
        end
        if (k > 20) begin
          chk("done_timeout", k, 17);
          mon_act = 0;
        end
      end
      if (DET) begin
        if (mon_act) dets++;
        else chk("det_outside_frame", DET, 0);
      end
      if (ACKA || ACKB) begin
        chk("ack_overlap", ACKA && ACKB, 0);
        chk("ack_while_busy", mon_act, 0);
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ack: got ACKA=%0b ACKB=%0b expected none", ACKA, ACKB);
        end else begin
          cur = expq.pop_front();
          chk("grant_src", ACKB, cur.src);
          chk("busy_load", BUSY, 1);
          chk("sdo_load", SDO, 0);
          if (pend && have_done) chk("idle_gap", cyc - done_cyc, 2);
          mon_act = 1;
          k = 0;
          dets = 0;
        end
      end
      if (DONE) begin
        if (!mon_act) chk("done_unexpected", DONE, 0);
        else begin
          chk("done_latency", k, 17);
          chk("busy_fin", BUSY, 0);
          chk("sdo_fin", SDO, 0);
          chk("src", SRC, cur.src);
          chk("hits", HITS, ref_hits(cur.data, 10));
          chk("det_count", dets, ref_hits(cur.data, 10));
          mon_act = 0;
          done_cyc = cyc;
          pend = REQA || REQB;
          have_done = 1;
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #2;
  endtask

  task automatic issue(bit ra, bit rb, logic [15:0] da, logic [15:0] db);
    bit win;
    int t;
    if (ra && !REQA) begin REQA = 1; DATA = da; end
    if (rb && !REQB) begin REQB = 1; DATB = db; end
    if (!REQA && !REQB) begin REQA = 1; DATA = da; end
    win = REQB && (!REQA || !last_b);
    last_b = win;
    expq.push_back('{win, win ? DATB : DATA});
    t = 0;
    do begin
      step();
      t++;
    end while (!(ACKA || ACKB) && t < 40);
    if (!(ACKA || ACKB)) begin
      checks++;
      fails++;
      $display("FAIL ack_timeout: got no ACK in %0d cycles expected one", t);
    end
    if (ACKA) begin REQA = 0; DATA = 16'($urandom); end
    if (ACKB) begin REQB = 0; DATB = 16'($urandom); end
  endtask

  task automatic drain();
    int t = 0;
    while ((REQA || REQB)) issue(0, 0, 16'h0, 16'h0);
    while (mon_act && t < 40) begin step(); t++; end
    chk("drain", mon_act, 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_sdo"}, SDO, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_det"}, DET, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_acka"}, ACKA, 0);
    chk({tag, "_ackb"}, ACKB, 0);
    chk({tag, "_src"}, SRC, 0);
    chk({tag, "_hits"}, HITS, 0);
  endtask

  initial begin : drv
    int t;
    int d4;
    RST = 1; REQA = 0; REQB = 0; DATA = 0; DATB = 0;
    reqa4 = 0; data4 = 0;
    repeat (3) step();
    chk_zero("reset");
    RST = 0;
    step();

    // Both requesting continuously: A,B,A,B
    issue(1, 1, 16'hA5A5, 16'h5A5A);
    issue(1, 0, 16'h1234, 16'h0);
    issue(0, 1, 16'h0, 16'hFFC0);
    issue(1, 0, 16'hFFFF, 16'h0);
    drain();

    issue(1, 0, 16'hFFFF, 16'h0);
    issue(1, 0, 16'hFFC0, 16'h0);
    issue(1, 0, 16'hFF80, 16'h0);
    drain();

    for (int i = 0; i < 30; i++)
      issue(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            rnd_data(), rnd_data());
    drain();

    // Reset during SHIFT bit 7 abandons the frame
    issue(1, 0, 16'hFFFF, 16'h0);
    repeat (7) step();
    RST = 1;
    step();
    chk_zero("midreset");
    RST = 0;
    last_b = 1;
    step();
    issue(0, 1, 16'h0, 16'hBEEF);
    drain();

    // RUN=4 instance: every 4th one detects, counter wraps to 1
    reqa4 = 1;
    data4 = 16'hFFFF;
    d4 = 0;
    t = 0;
    while (!done4 && t < 40) begin
      step();
      t++;
      if (acka4) reqa4 = 0;
      if (det4) d4++;
    end
    chk("run4_done_seen", done4, 1);
    chk("run4_hits", hits4, ref_hits(16'hFFFF, 4));
    chk("run4_det_count", d4, ref_hits(16'hFFFF, 4));
    chk("run4_src", src4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

endmodule
